// File: rtl/iprefetch_stream_buffer.sv
// Sequential-line instruction prefetch stream buffer between I-cache and slow memory.
// Optional hit/miss counters are built when PF_STATS_EN is defined.
module iprefetch_stream_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 28
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [127:0]      cache_wdata,
  output logic [127:0]      cache_rdata,
  output logic              cache_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
`ifdef PF_STATS_EN
  ,
  output logic [15:0]       stat_hit,
  output logic [15:0]       stat_miss
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DEMAND,
    PREFETCH,
    WRITE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [ADDR_W-1:0] tag_d  [DEPTH];
  logic [127:0]      data_q [DEPTH];
  logic [127:0]      data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     head_q, head_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] next_pf_q, next_pf_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [127:0]      wdata_q, wdata_d;
  logic [127:0]      rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              rdy_q, rdy_d;

  logic              hit;
  logic [CW-1:0]     hit_k;
  logic [PW-1:0]     hit_idx;
  logic [PW-1:0]     tail;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % DEPTH);
  endfunction

  // Search only the occupied slots, oldest first; hit_k is the offset from head.
  always_comb begin
    hit     = 1'b0;
    hit_k   = '0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!hit && (k < int'(count_q))
          && valid_q[wrap(int'(head_q) + k)]
          && (tag_q[wrap(int'(head_q) + k)] == cache_addr)) begin
        hit     = 1'b1;
        hit_k   = CW'(k);
        hit_idx = wrap(int'(head_q) + k);
      end
    end
  end

  assign tail = wrap(int'(head_q) + int'(count_q));

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    data_d    = data_q;
    valid_d   = valid_q;
    head_d    = head_q;
    count_d   = count_q;
    next_pf_d = next_pf_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rdy_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rdy_q) begin
          if (cache_write) begin
            for (int k = 0; k < DEPTH; k++) begin
              if (valid_q[k] && (tag_q[k] == cache_addr)) begin
                valid_d[k] = 1'b0;
              end
            end
            wr_d    = 1'b1;
            maddr_d = cache_addr;
            wdata_d = cache_wdata;
            state_d = WRITE;
          end else if (cache_read && hit) begin
            rdy_d   = 1'b1;
            rdata_d = data_q[hit_idx];
            for (int k = 0; k < DEPTH; k++) begin
              if (CW'(k) <= hit_k) begin
                valid_d[wrap(int'(head_q) + k)] = 1'b0;
              end
            end
            head_d  = wrap(int'(hit_idx) + 1);
            count_d = count_q - hit_k - CW'(1);
            state_d = (int'(count_d) < DEPTH) ? PREFETCH : IDLE;
          end else if (cache_read) begin
            valid_d = '0;
            head_d  = '0;
            count_d = '0;
            rd_d    = 1'b1;
            maddr_d = cache_addr;
            state_d = DEMAND;
          end
        end
      end
      DEMAND: begin
        if (mem_ready) begin
          rd_d      = 1'b0;
          rdy_d     = 1'b1;
          rdata_d   = mem_rdata;
          next_pf_d = maddr_q + ADDR_W'(1);
          state_d   = PREFETCH;
        end
      end
      PREFETCH: begin
        // One idle cycle separates consecutive memory requests.
        if (rd_q && mem_ready) begin
          tag_d[tail]   = next_pf_q;
          data_d[tail]  = mem_rdata;
          valid_d[tail] = 1'b1;
          count_d       = count_q + CW'(1);
          next_pf_d     = next_pf_q + ADDR_W'(1);
          rd_d          = 1'b0;
          if (int'(count_q) + 1 >= DEPTH) begin
            state_d = IDLE;
          end
        end else if (!rd_q) begin
          rd_d    = 1'b1;
          maddr_d = next_pf_q;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          wr_d    = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q   <= IDLE;
      tag_q     <= '{default: '0};
      data_q    <= '{default: '0};
      valid_q   <= '0;
      head_q    <= '0;
      count_q   <= '0;
      next_pf_q <= '0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      count_q   <= count_d;
      next_pf_q <= next_pf_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rdy_q     <= rdy_d;
    end
  end

  assign cache_rdata = rdata_q;
  assign cache_ready = rdy_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_addr    = maddr_q;
  assign mem_wdata   = wdata_q;

`ifdef PF_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        acc_rd;

  assign acc_rd = (state_q == IDLE) && !rdy_q && cache_read && !cache_write;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (acc_rd && hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (acc_rd && !hit && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign stat_hit  = hit_cnt_q;
  assign stat_miss = miss_cnt_q;
`endif

endmodule

// File: tb/tb_iprefetch_stream_buffer.sv
// Scoreboard bench for iprefetch_stream_buffer: fixed-latency memory model,
// expected cache responses and memory transactions checked by monitors.
module tb_iprefetch_stream_buffer;

  localparam int AW  = 28;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          cache_read;
  logic          cache_write;
  logic [AW-1:0] cache_addr;
  logic [127:0]  cache_wdata;
  logic [127:0]  cache_rdata;
  logic          cache_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
`ifdef PF_STATS_EN
  logic [15:0]   stat_hit;
  logic [15:0]   stat_miss;
`endif

  iprefetch_stream_buffer #(.DEPTH(2), .ADDR_W(AW)) dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .cache_read  (cache_read),
    .cache_write (cache_write),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_rdata (cache_rdata),
    .cache_ready (cache_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
`ifdef PF_STATS_EN
    ,
    .stat_hit    (stat_hit),
    .stat_miss   (stat_miss)
`endif
  );

  always #5 clk = ~clk;

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int inv_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [127:0]  wdata;
  } mem_t;

  mem_t         memq[$];
  logic [127:0] cq[$];

  function automatic logic [127:0] line(input logic [AW-1:0] a);
    return {4'hA, a, 4'hB, ~a, 4'hC, a + 28'd7, 4'hD, a ^ 28'h1234567};
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic wr, input logic [AW-1:0] a,
                          input logic [127:0] d);
    mem_t e;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = d;
    memq.push_back(e);
  endtask

  // Memory model: answers each request after LAT cycles and checks it.
  initial begin
    int   cnt;
    mem_t e;
    cnt       = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) inv_err++;
      if (proc_reset) begin
        cnt       = 0;
        mem_ready = 1'b0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt == LAT) begin
          cnt       = 0;
          mem_ready = 1'b1;
          mem_rdata = line(mem_addr);
          if (memq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mem_unexpected: got wr=%0b addr %h, required no request",
                     mem_write, mem_addr);
          end else begin
            e = memq.pop_front();
            chk("mem_op_wr", 128'(mem_write), 128'(e.wr));
            chk("mem_addr", 128'(mem_addr), 128'(e.addr));
            if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
          end
        end
      end
    end
  end

  // Cache-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (cache_ready) begin
        if (cq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected: got %h, required no response", cache_rdata);
        end else begin
          chk("cache_rdata", cache_rdata, cq.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [127:0] d);
    cache_read  = !wr;
    cache_write = wr;
    cache_addr  = a;
    cache_wdata = d;
  endtask

  task automatic wait_resp(output int lat);
    int start;
    int n;
    start = cyc;
    n     = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cache_ready && n < 200);
    if (!cache_ready) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no cache_ready in %0d cycles, required one", n);
    end
    lat         = cyc - start;
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (memq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (memq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL mem_timeout: got %0d requests outstanding, required 0", memq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Read of a; miss also expects the demand fetch; then npf prefetches from pf.
  task automatic rd(input string name, input logic [AW-1:0] a, input bit miss,
                    input logic [AW-1:0] pf, input int npf);
    int lat;
    if (miss) push_mem(1'b0, a, '0);
    for (int i = 0; i < npf; i++) push_mem(1'b0, pf + AW'(i), '0);
    cq.push_back(line(a));
    issue(1'b0, a, '0);
    wait_resp(lat);
    chk({name, "_latency"}, 128'(lat), miss ? 128'd5 : 128'd1);
    wait_idle();
  endtask

  initial begin
    int           lat;
    logic [127:0] wd;
    proc_reset  = 1'b1;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    cache_addr  = '0;
    cache_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", 128'(mem_read), 128'd0);
    chk("rst_mem_write", 128'(mem_write), 128'd0);
    chk("rst_cache_ready", 128'(cache_ready), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_cache_rdata", cache_rdata, 128'd0);
    proc_reset = 1'b0;
    @(negedge clk);

    rd("cold_10", 28'h0000010, 1'b1, 28'h0000011, 2);
    rd("hit_11", 28'h0000011, 1'b0, 28'h0000013, 1);
    rd("flush_50", 28'h0000050, 1'b1, 28'h0000051, 2);
    rd("miss_11", 28'h0000011, 1'b1, 28'h0000012, 2);

    wd = {16{8'hA5}};
    push_mem(1'b1, 28'h0000012, wd);
    cq.push_back(line(28'h0000011));
    issue(1'b1, 28'h0000012, wd);
    wait_resp(lat);
    chk("write_latency", 128'(lat), 128'd5);
    wait_idle();

    rd("inval_12", 28'h0000012, 1'b1, 28'h0000013, 2);
    rd("hit_13", 28'h0000013, 1'b0, 28'h0000015, 1);
    rd("wrap_fff", 28'hFFFFFFF, 1'b1, 28'h0000000, 2);
    rd("hit_000", 28'h0000000, 1'b0, 28'h0000002, 1);
    rd("hit_002", 28'h0000002, 1'b0, 28'h0000003, 2);

    push_mem(1'b0, 28'h0000020, '0);
    cq.push_back(line(28'h0000020));
    issue(1'b0, 28'h0000020, '0);
    wait_resp(lat);
    chk("miss_20_latency", 128'(lat), 128'd5);
    issue(1'b0, 28'h0000040, '0);
    repeat (2) @(negedge clk);
    chk("pf_pending_read", 128'(mem_read), 128'd1);
    chk("pf_pending_addr", 128'(mem_addr), 128'h21);
    proc_reset = 1'b1;
    #1;
    chk("async_mem_read", 128'(mem_read), 128'd0);
    chk("async_mem_addr", 128'(mem_addr), 128'd0);
    chk("async_cache_ready", 128'(cache_ready), 128'd0);
    chk("async_cache_rdata", cache_rdata, 128'd0);
    repeat (2) @(negedge clk);
    push_mem(1'b0, 28'h0000040, '0);
    push_mem(1'b0, 28'h0000041, '0);
    push_mem(1'b0, 28'h0000042, '0);
    cq.push_back(line(28'h0000040));
    proc_reset = 1'b0;
    wait_resp(lat);
    wait_idle();

    chk("cache_queue_drained", 128'(cq.size()), 128'd0);
    chk("mem_queue_drained", 128'(memq.size()), 128'd0);
    chk("rd_wr_exclusive", 128'(inv_err), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
